product_capture: RTL and testbench

PRODUCT_CAPTURE -- requirements
Module: product_capture

---
 rtl/product_capture_pkg.sv | 21 ++
 rtl/product_capture_prod_fifo.sv | 84 ++++++++
 rtl/product_capture.sv | 96 +++++++++
 tb/tb_product_capture.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/product_capture_pkg.sv
// Shared types and constants for the product capture block.
// The optional accumulator is enabled with the PRODUCT_CAPTURE_ACCUM_EN macro.
package product_capture_pkg;

    localparam int unsigned PROD_W = 16;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        WAIT_LOW = 2'd2
    } cap_state_e;

    // Sign-extend a captured product to accumulator width.
    function automatic logic [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
        return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
    endfunction

endpackage

// File: rtl/product_capture_prod_fifo.sv
// History storage for captured products: circular buffer with head/tail
// pointers, occupancy count and a registered read of the oldest entry.
module prod_fifo
    import product_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = PROD_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [W-1:0]     wdata,
    input  logic             pop,
    input  logic             clear,
    output logic [W-1:0]     rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             wr_drop_c
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [AW-1:0]    head;
    logic [AW-1:0]    tail;
    logic [AW-1:0]    rd_idx;
    logic [W-1:0]     mem [DEPTH];
    logic             pop_ok;
    logic             wr_ok;
    logic [CNT_W-1:0] count_next;
    logic [W-1:0]     rdata_next;

    // Accept/drop decisions, next occupancy and next head value (with write forwarding).
    always_comb begin
        pop_ok     = !rst && !clear && pop && !empty;
        wr_ok      = !rst && !clear && wr && (!full || pop_ok);
        wr_drop_c  = !rst && !clear && wr && full && !pop_ok;
        rd_idx     = pop_ok ? head + AW'(1) : head;
        count_next = count;
        case ({wr_ok, pop_ok})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
        rdata_next = mem[rd_idx];
        if (wr_ok && (tail == rd_idx)) begin
            rdata_next = wdata;
        end
        if (count_next == '0) begin
            rdata_next = '0;
        end
    end

    // Pointers, count, flags and head read register.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            rdata <= '0;
            empty <= 1'b1;
            full  <= 1'b0;
        end else begin
            if (wr_ok) begin
                tail <= tail + AW'(1);
            end
            if (pop_ok) begin
                head <= head + AW'(1);
            end
            count <= count_next;
            rdata <= rdata_next;
            empty <= (count_next == '0);
            full  <= (count_next == CNT_W'(DEPTH));
        end
    end

    // Storage array; contents are not reset, the empty state masks stale data.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[tail] <= wdata;
        end
    end

endmodule

// File: rtl/product_capture.sv
// Captures one multiplier product per Done high period into a small history,
// with pop-edge readout, sticky overflow and an optional running sum.
// Optional feature macro: PRODUCT_CAPTURE_ACCUM_EN (accumulator in Acc).
module product_capture
    import product_capture_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PW    = PROD_W
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Done,
    input  logic [BYTE_W-1:0] Aval,
    input  logic [BYTE_W-1:0] Bval,
    input  logic              Pop,
    input  logic              Clear,
    output logic [PW-1:0]     Prod,
    output logic [CNT_W-1:0]  Count,
    output logic              Empty,
    output logic              Full,
    output logic              Overflow,
    output logic [ACC_W-1:0]  Acc
);

    cap_state_e    state;
    logic          pop_q;
    logic          pop_edge_c;
    logic          wr_c;
    logic          wr_drop_c;
    logic [PW-1:0] wdata_c;

    assign pop_edge_c = Pop && !pop_q;
    assign wr_c       = (state == WRITE);
    assign wdata_c    = PW'({Aval, Bval});

    // Capture FSM, pop edge register and sticky overflow flag.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            pop_q    <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            pop_q <= Pop;
            if (Clear) begin
                state    <= WAIT_LOW;
                Overflow <= 1'b0;
            end else begin
                if (wr_drop_c) begin
                    Overflow <= 1'b1;
                end
                case (state)
                    IDLE:     state <= Done ? WRITE : IDLE;
                    WRITE:    state <= WAIT_LOW;
                    WAIT_LOW: state <= Done ? WAIT_LOW : IDLE;
                    default:  state <= IDLE;
                endcase
            end
        end
    end

    prod_fifo #(
        .DEPTH (DEPTH),
        .W     (PW)
    ) u_fifo (
        .clk       (Clk),
        .rst       (Reset),
        .wr        (wr_c),
        .wdata     (wdata_c),
        .pop       (pop_edge_c),
        .clear     (Clear),
        .rdata     (Prod),
        .count     (Count),
        .empty     (Empty),
        .full      (Full),
        .wr_drop_c (wr_drop_c)
    );

`ifdef PRODUCT_CAPTURE_ACCUM_EN
    logic accept_c;

    // A write lands when there is room or a pop frees a slot in the same cycle.
    assign accept_c = wr_c && !Clear && (!Full || (pop_edge_c && !Empty));

    // Modular running sum of accepted products.
    always_ff @(posedge Clk) begin
        if (Reset || Clear) begin
            Acc <= '0;
        end else if (accept_c) begin
            Acc <= Acc + sext_prod(PROD_W'(wdata_c));
        end
    end
`else
    assign Acc = '0;
`endif

endmodule

// File: tb/tb_product_capture.sv
// Directed self-checking bench for product_capture (DEPTH=4).
module tb_product_capture;
    import product_capture_pkg::*;

    logic              Clk;
    logic              Reset;
    logic              Done;
    logic [BYTE_W-1:0] Aval;
    logic [BYTE_W-1:0] Bval;
    logic              Pop;
    logic              Clear;
    logic [PROD_W-1:0] Prod;
    logic [CNT_W-1:0]  Count;
    logic              Empty;
    logic              Full;
    logic              Overflow;
    logic [ACC_W-1:0]  Acc;

    int errors = 0;
    int checks = 0;

    product_capture #(.DEPTH(4), .PW(PROD_W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Done     (Done),
        .Aval     (Aval),
        .Bval     (Bval),
        .Pop      (Pop),
        .Clear    (Clear),
        .Prod     (Prod),
        .Count    (Count),
        .Empty    (Empty),
        .Full     (Full),
        .Overflow (Overflow),
        .Acc      (Acc)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic capture(input logic [15:0] v);
        {Aval, Bval} = v;
        Done = 1'b1;
        step();
        step();
        Done = 1'b0;
        step();
    endtask

    task automatic pop_one();
        Pop = 1'b1;
        step();
        Pop = 1'b0;
        step();
    endtask

    initial begin
        logic [ACC_W-1:0] acc_exp;
        Reset = 1'b1; Done = 1'b0; Aval = '0; Bval = '0; Pop = 1'b0; Clear = 1'b0;
        step();
        step();
        Reset = 1'b0;
        chk("rst_count", 32'(Count), 32'd0);
        chk("rst_empty", 32'(Empty), 32'd1);
        chk("rst_full", 32'(Full), 32'd0);
        chk("rst_ovf", 32'(Overflow), 32'd0);
        chk("rst_prod", 32'(Prod), 32'd0);
        chk("rst_acc", 32'(Acc), 32'd0);

        // Long Done pulse yields exactly one capture, visible on the second edge.
        Aval = 8'hFF; Bval = 8'hF8; Done = 1'b1;
        step();
        chk("lat_count_early", 32'(Count), 32'd0);
        step();
        chk("lat_count", 32'(Count), 32'd1);
        chk("lat_prod", 32'(Prod), 32'h0000FFF8);
        repeat (8) step();
        chk("long_done_count", 32'(Count), 32'd1);
        chk("long_done_prod", 32'(Prod), 32'h0000FFF8);
        Done = 1'b0;
        step();
        step();
        pop_one();
        chk("pop1_empty", 32'(Empty), 32'd1);
        chk("pop1_prod", 32'(Prod), 32'd0);

        // Five captures into a 4-deep history: last one dropped.
        for (int i = 1; i <= 5; i++) capture(16'(i));
        chk("ovf_full", 32'(Full), 32'd1);
        chk("ovf_flag", 32'(Overflow), 32'd1);
        chk("ovf_count", 32'(Count), 32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("ovf_pop_prod", 32'(Prod), 32'(i));
            pop_one();
        end
        chk("ovf_drain_empty", 32'(Empty), 32'd1);
        chk("ovf_drain_prod", 32'(Prod), 32'd0);
        chk("ovf_sticky", 32'(Overflow), 32'd1);
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        chk("clr_ovf", 32'(Overflow), 32'd0);
        step();

        // Full history: write and pop edge in the same cycle.
        for (int i = 10; i <= 13; i++) capture(16'(i));
        chk("wp_full", 32'(Full), 32'd1);
        {Aval, Bval} = 16'd14;
        Done = 1'b1;
        step();
        Pop = 1'b1;
        step();
        Pop = 1'b0;
        Done = 1'b0;
        chk("wp_count", 32'(Count), 32'd4);
        chk("wp_ovf", 32'(Overflow), 32'd0);
        chk("wp_full_hold", 32'(Full), 32'd1);
        step();
        for (int i = 11; i <= 14; i++) begin
            chk("wp_order", 32'(Prod), 32'(i));
            pop_one();
        end
        chk("wp_empty", 32'(Empty), 32'd1);

        // Pop on empty is ignored.
        pop_one();
        chk("uf_count", 32'(Count), 32'd0);
        chk("uf_empty", 32'(Empty), 32'd1);
        capture(16'h0007);
        chk("uf_next_prod", 32'(Prod), 32'd7);
        chk("uf_next_count", 32'(Count), 32'd1);
        pop_one();

        // Clear while Done is high: no recapture until Done falls and rises.
        for (int i = 21; i <= 23; i++) capture(16'(i));
        chk("clr_pre_count", 32'(Count), 32'd3);
        {Aval, Bval} = 16'd24;
        Done = 1'b1;
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        repeat (5) step();
        chk("clr_count", 32'(Count), 32'd0);
        chk("clr_empty", 32'(Empty), 32'd1);
        chk("clr_ovf2", 32'(Overflow), 32'd0);
        chk("clr_prod", 32'(Prod), 32'd0);
        Done = 1'b0;
        step();
        step();
        capture(16'd24);
        chk("clr_recap_count", 32'(Count), 32'd1);
        chk("clr_recap_prod", 32'(Prod), 32'd24);

        // Accumulator wrap behaviour.
        Clear = 1'b1;
        step();
        Clear = 1'b0;
        step();
        chk("acc_clr", 32'(Acc), 32'd0);
        capture(16'h7FFF);
`ifdef PRODUCT_CAPTURE_ACCUM_EN
        acc_exp = 24'h007FFF;
`else
        acc_exp = 24'h000000;
`endif
        chk("acc_1", 32'(Acc), 32'(acc_exp));
        capture(16'h8000);
`ifdef PRODUCT_CAPTURE_ACCUM_EN
        acc_exp = 24'hFFFFFF;
`endif
        chk("acc_2", 32'(Acc), 32'(acc_exp));
        capture(16'h0002);
`ifdef PRODUCT_CAPTURE_ACCUM_EN
        acc_exp = 24'h000001;
`endif
        chk("acc_3", 32'(Acc), 32'(acc_exp));
        chk("acc_prod_head", 32'(Prod), 32'h00007FFF);

        // Reset while in WRITE aborts the capture.
        {Aval, Bval} = 16'h0055;
        Done = 1'b1;
        step();
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        Done = 1'b0;
        chk("rstw_count", 32'(Count), 32'd0);
        chk("rstw_empty", 32'(Empty), 32'd1);
        chk("rstw_prod", 32'(Prod), 32'd0);
        chk("rstw_acc", 32'(Acc), 32'd0);
        step();
        step();
        chk("rstw_after", 32'(Count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
